dma_l2_scheduler: RTL and testbench

DMA_L2_SCHEDULER -- requirements
Module: dma_l2_scheduler

---
 rtl/dma_l2_scheduler.sv | 143 ++++++++++++++
 tb/tb_dma_l2_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dma_l2_scheduler.sv
// Round-robin scheduler that grants cluster DMA requests to the shared L2 port and tracks per-cluster outstanding credits.
// Optional per-cluster accepted-grant statistics are enabled with the DMA_SCHED_STATS_EN macro.
module dma_l2_scheduler #(
    parameter int NumClusters    = 4,
    parameter int MaxOutstanding = 4,
    // Derived widths; kept as localparams so they cannot be overridden.
    localparam int IdxWidth = (NumClusters > 1) ? $clog2(NumClusters) : 1,
    localparam int CntWidth = (MaxOutstanding > 0) ? $clog2(MaxOutstanding + 1) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumClusters-1:0] req_valid_i,
    output logic [NumClusters-1:0] req_ready_o,
    output logic                   grant_valid_o,
    output logic [IdxWidth-1:0]    grant_idx_o,
    input  logic                   grant_ready_i,
    input  logic                   cpl_valid_i,
    input  logic [IdxWidth-1:0]    cpl_idx_i,
    output logic                   cpl_err_o,
    output logic                   busy_o,
    input  logic [IdxWidth-1:0]    stats_idx_i,
    output logic [31:0]            stats_cnt_o
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]          r_state;
    logic [IdxWidth-1:0] r_grant_idx;
    logic [IdxWidth-1:0] r_rr_ptr;
    logic [CntWidth-1:0] r_outstanding [NumClusters];
    logic                r_cpl_err;

    logic [NumClusters-1:0] w_eligible;
    logic [NumClusters-1:0] w_dec;
    logic [NumClusters-1:0] w_req_ready;
    logic                   w_cap_allow;
    logic                   w_found;
    logic [IdxWidth-1:0]    w_pick_idx;
    logic                   w_cpl_err;
    logic                   w_any_out;

    always_comb begin
        w_any_out = 1'b0;
        for (int i = 0; i < NumClusters; i++) begin
            w_eligible[i] = req_valid_i[i] && (r_outstanding[i] < CntWidth'(MaxOutstanding));
            w_dec[i]      = cpl_valid_i && (cpl_idx_i == IdxWidth'(i)) && (r_outstanding[i] != '0);
            w_any_out     = w_any_out || (r_outstanding[i] != '0);
        end
    end

    // Scan downward so the smallest offset from the pointer wins.
    always_comb begin
        w_found    = 1'b0;
        w_pick_idx = '0;
        for (int k = NumClusters - 1; k >= 0; k--) begin
            int                  j;
            logic [IdxWidth-1:0] cand;
            j = int'(r_rr_ptr) + k;
            if (j >= NumClusters) j = j - NumClusters;
            cand = IdxWidth'(j);
            if (w_eligible[cand]) begin
                w_found    = 1'b1;
                w_pick_idx = cand;
            end
        end
    end

    assign w_cap_allow = (r_state == IDLE) || grant_ready_i;

    always_comb begin
        for (int i = 0; i < NumClusters; i++) begin
            w_req_ready[i] = !rst_i && w_cap_allow && w_found && (w_pick_idx == IdxWidth'(i));
        end
    end

    // A completion that frees nothing (zero count or unknown cluster) is flagged instead.
    assign w_cpl_err = cpl_valid_i && !(|w_dec);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_cpl_err   <= 1'b0;
        end else begin
            r_cpl_err <= w_cpl_err;
            if (w_cap_allow) begin
                if (w_found) begin
                    r_state     <= GRANT;
                    r_grant_idx <= w_pick_idx;
                    r_rr_ptr    <= (w_pick_idx == IdxWidth'(NumClusters - 1)) ? '0 : w_pick_idx + 1'b1;
                end else begin
                    r_state <= IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumClusters; i++) begin
            if (rst_i) begin
                r_outstanding[i] <= '0;
            end else if (w_req_ready[i] && !w_dec[i]) begin
                r_outstanding[i] <= r_outstanding[i] + 1'b1;
            end else if (!w_req_ready[i] && w_dec[i]) begin
                r_outstanding[i] <= r_outstanding[i] - 1'b1;
            end
        end
    end

`ifdef DMA_SCHED_STATS_EN
    logic [31:0] r_stats [NumClusters];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumClusters; i++) begin
            if (rst_i) begin
                r_stats[i] <= '0;
            end else if ((r_state == GRANT) && grant_ready_i && (r_grant_idx == IdxWidth'(i))) begin
                r_stats[i] <= r_stats[i] + 32'd1;
            end
        end
    end

    always_comb begin
        stats_cnt_o = '0;
        for (int i = 0; i < NumClusters; i++) begin
            if (stats_idx_i == IdxWidth'(i)) stats_cnt_o = r_stats[i];
        end
    end
`else
    logic w_unused_stats_idx;
    assign w_unused_stats_idx = ^stats_idx_i;
    assign stats_cnt_o        = '0;
`endif

    assign req_ready_o   = w_req_ready;
    assign grant_valid_o = (r_state == GRANT);
    assign grant_idx_o   = r_grant_idx;
    assign cpl_err_o     = r_cpl_err;
    assign busy_o        = (r_state == GRANT) || w_any_out;

endmodule

// File: tb/tb_dma_l2_scheduler.sv
// Table-driven bench for dma_l2_scheduler (4 clusters, 2 credits each) with a grant scoreboard.
module tb_dma_l2_scheduler;

    localparam int NC = 4;
    localparam int MO = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [NC-1:0] req_valid_i;
    logic [NC-1:0] req_ready_o;
    logic          grant_valid_o;
    logic [1:0]    grant_idx_o;
    logic          grant_ready_i;
    logic          cpl_valid_i;
    logic [1:0]    cpl_idx_i;
    logic          cpl_err_o;
    logic          busy_o;
    logic [1:0]    stats_idx_i;
    logic [31:0]   stats_cnt_o;

    always #5 clk_i = ~clk_i;

    dma_l2_scheduler #(.NumClusters(NC), .MaxOutstanding(MO)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .grant_valid_o(grant_valid_o),
        .grant_idx_o  (grant_idx_o),
        .grant_ready_i(grant_ready_i),
        .cpl_valid_i  (cpl_valid_i),
        .cpl_idx_i    (cpl_idx_i),
        .cpl_err_o    (cpl_err_o),
        .busy_o       (busy_o),
        .stats_idx_i  (stats_idx_i),
        .stats_cnt_o  (stats_cnt_o)
    );

    typedef struct {
        logic       rst;
        logic [3:0] rv;
        logic       gr;
        logic       cv;
        logic [1:0] ci;
        logic [3:0] e_rdy;
        logic       e_gv;
        logic [1:0] e_idx;
        logic       e_err;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];
    int   exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    function automatic void add(input logic rst, input logic [3:0] rv, input logic gr, input logic cv,
                                input logic [1:0] ci, input logic [3:0] e_rdy, input logic e_gv,
                                input logic [1:0] e_idx, input logic e_err, input logic e_busy);
        vec_t v;
        v.rst = rst; v.rv = rv; v.gr = gr; v.cv = cv; v.ci = ci;
        v.e_rdy = e_rdy; v.e_gv = e_gv; v.e_idx = e_idx; v.e_err = e_err; v.e_busy = e_busy;
        tbl.push_back(v);
    endfunction

    function automatic void add_rst();
        add(1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    endfunction

    task automatic apply_row(input int r, input vec_t v);
        rst_i         = v.rst;
        req_valid_i   = v.rv;
        grant_ready_i = v.gr;
        cpl_valid_i   = v.cv;
        cpl_idx_i     = v.ci;
        if (v.rst) exp_q.delete();
        #1;
        check("req_ready", r, 32'(req_ready_o), 32'(v.e_rdy));
        for (int i = 0; i < NC; i++) if (v.e_rdy[i]) exp_q.push_back(i);
        @(posedge clk_i);
        #1;
        check("grant_valid", r, 32'(grant_valid_o), 32'(v.e_gv));
        check("grant_idx", r, 32'(grant_idx_o), 32'(v.e_idx));
        check("cpl_err", r, 32'(cpl_err_o), 32'(v.e_err));
        check("busy", r, 32'(busy_o), 32'(v.e_busy));
        if (v.rst) check("stats_after_reset", r, stats_cnt_o, 32'd0);
    endtask

    // Every accepted grant must match the oldest expected capture.
    always @(negedge clk_i) begin
        int e;
        if (rst_i === 1'b0 && grant_valid_o === 1'b1 && grant_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_unexpected_accept: got idx %0d expected no acceptance", grant_idx_o);
            end else begin
                e = exp_q.pop_front();
                check("sb_grant_idx", -1, 32'(grant_idx_o), 32'(e));
            end
        end
    end

    initial begin
        vec_t v;
        rst_i = 1'b1; req_valid_i = '0; grant_ready_i = 1'b0;
        cpl_valid_i = 1'b0; cpl_idx_i = '0; stats_idx_i = 2'd2;

        // Back-to-back round robin, then drain
        add_rst();
        add_rst();
        add(0, 4'hF, 1, 0, 0, 4'h1, 1, 0, 0, 1);
        add(0, 4'hF, 1, 0, 0, 4'h2, 1, 1, 0, 1);
        add(0, 4'hF, 1, 0, 0, 4'h4, 1, 2, 0, 1);
        add(0, 4'hF, 1, 0, 0, 4'h8, 1, 3, 0, 1);
        add(0, 4'hF, 1, 0, 0, 4'h1, 1, 0, 0, 1);
        add(0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 0, 1);
        // Credit limit on cluster 1 and release by completion
        add_rst();
        add(0, 4'h2, 1, 0, 0, 4'h2, 1, 1, 0, 1);
        add(0, 4'h2, 1, 0, 0, 4'h2, 1, 1, 0, 1);
        add(0, 4'h2, 1, 0, 0, 4'h0, 0, 1, 0, 1);
        add(0, 4'h2, 1, 0, 0, 4'h0, 0, 1, 0, 1);
        add(0, 4'h2, 1, 1, 1, 4'h0, 0, 1, 0, 1);
        add(0, 4'h2, 1, 0, 0, 4'h2, 1, 1, 0, 1);
        add(0, 4'h0, 1, 0, 0, 4'h0, 0, 1, 0, 1);
        // Held grant on cluster 2 under back-pressure
        add_rst();
        add(0, 4'h4, 0, 0, 0, 4'h4, 1, 2, 0, 1);
        for (int i = 0; i < 5; i++) add(0, 4'hF, 0, 0, 0, 4'h0, 1, 2, 0, 1);
        add(0, 4'h0, 1, 0, 0, 4'h0, 0, 2, 0, 1);
        // Spurious completion, then simultaneous grant and completion on cluster 0
        add_rst();
        add(0, 4'h0, 0, 1, 3, 4'h0, 0, 0, 1, 0);
        add(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        add(0, 4'h1, 1, 0, 0, 4'h1, 1, 0, 0, 1);
        add(0, 4'h1, 1, 1, 0, 4'h1, 1, 0, 0, 1);
        add(0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 0, 1);
        add(0, 4'h1, 1, 0, 0, 4'h1, 1, 0, 0, 1);
        add(0, 4'h1, 1, 0, 0, 4'h0, 0, 0, 0, 1);
        // Build outstanding {1,2,0,1}, reset mid-grant, restart from index 0
        add_rst();
        add(0, 4'hB, 1, 0, 0, 4'h1, 1, 0, 0, 1);
        add(0, 4'hB, 1, 0, 0, 4'h2, 1, 1, 0, 1);
        add(0, 4'hB, 1, 0, 0, 4'h8, 1, 3, 0, 1);
        add(0, 4'h2, 1, 0, 0, 4'h2, 1, 1, 0, 1);
        add(0, 4'h2, 0, 0, 0, 4'h0, 1, 1, 0, 1);
        add_rst();
        add(0, 4'hE, 1, 0, 0, 4'h2, 1, 1, 0, 1);
        add(0, 4'h0, 1, 0, 0, 4'h0, 0, 1, 0, 1);

        for (int r = 0; r < tbl.size(); r++) apply_row(r, tbl[r]);

        // Statistics: three accepted grants for cluster 2, recycling credits via completions
        tbl.delete();
        add_rst();
        add(0, 4'h4, 1, 0, 0, 4'h4, 1, 2, 0, 1);
        add(0, 4'h4, 1, 1, 2, 4'h4, 1, 2, 0, 1);
        add(0, 4'h4, 1, 1, 2, 4'h4, 1, 2, 0, 1);
        add(0, 4'h0, 1, 0, 0, 4'h0, 0, 2, 0, 1);
        for (int r = 0; r < tbl.size(); r++) begin
            v = tbl[r];
            apply_row(100 + r, v);
        end
        stats_idx_i = 2'd2;
        #1;
`ifdef DMA_SCHED_STATS_EN
        check("stats_cluster2", 200, stats_cnt_o, 32'd3);
`else
        check("stats_cluster2", 200, stats_cnt_o, 32'd0);
`endif
        stats_idx_i = 2'd1;
        #1;
        check("stats_cluster1", 201, stats_cnt_o, 32'd0);

        @(negedge clk_i);
        check("sb_drain", 202, 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
